// File: rtl/pe_ctx_sequencer.sv
// Per-PE context sequencer: loads a context program over valid/ready, then replays it one word per cycle.
// Optional PE_CTX_LOOP_EN adds loop_cnt_i/iter_o for back-to-back repeated passes.
module pe_ctx_sequencer #(
    parameter int CTX_W = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [CTX_W-1:0]   cfg_data_i,
    input  logic               cfg_last_i,
    input  logic               cfg_clr_i,
    input  logic               start_i,
    input  logic               stall_i,
`ifdef PE_CTX_LOOP_EN
    input  logic [7:0]         loop_cnt_i,
    output logic [7:0]         iter_o,
`endif
    output logic [3:0]         reg_file_inst_o,
    output logic [CTX_W-5:0]   ctx_rest_o,
    output logic               ctx_valid_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               cfg_err_o
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;

    state_t             state_q;
    logic [AW-1:0]      wptr_q;
    logic [AW:0]        len_q;
    logic [AW-1:0]      pc_q;
    logic               last_q;
    logic [3:0]         rf_q;
    logic [CTX_W-5:0]   rest_q;
    logic               vld_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic               rdy_q;
    logic [CTX_W-1:0]   mem [DEPTH];

    logic               cfg_acc;
    logic [AW:0]        len_m1;
    logic               pc_end;
    logic               last_d;
    logic [AW-1:0]      pc_d;
    logic [CTX_W-1:0]   word;
`ifdef PE_CTX_LOOP_EN
    logic [7:0]         iter_q;
    logic [7:0]         loop_q;
    logic [7:0]         iter_d;
`endif

    assign cfg_acc = cfg_valid_i && rdy_q && (state_q == S_IDLE);
    assign len_m1  = len_q - (AW+1)'(1);
    assign pc_end  = (pc_q == len_m1[AW-1:0]);
    assign word    = mem[pc_q];

    // Any issue at pc 0 while already issuing is a wrap into a new pass.
    always_comb begin
`ifdef PE_CTX_LOOP_EN
        iter_d = iter_q + ((vld_q && pc_q == '0) ? 8'd1 : 8'd0);
        last_d = pc_end && (iter_d == loop_q);
        pc_d   = pc_end ? '0 : pc_q + AW'(1);
`else
        last_d = pc_end;
        pc_d   = pc_end ? pc_q : pc_q + AW'(1);
`endif
    end

    always_ff @(posedge clk_i) begin
        if (cfg_acc)
            mem[wptr_q] <= cfg_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            len_q   <= '0;
            pc_q    <= '0;
            last_q  <= 1'b0;
            rf_q    <= '0;
            rest_q  <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
`ifdef PE_CTX_LOOP_EN
            iter_q  <= '0;
            loop_q  <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    rdy_q <= 1'b1;
                    if (cfg_acc) begin
                        wptr_q <= wptr_q + AW'(1);
                        if (cfg_last_i || wptr_q == AW'(DEPTH-1)) begin
                            len_q   <= {1'b0, wptr_q} + (AW+1)'(1);
                            err_q   <= !cfg_last_i;
                            rdy_q   <= 1'b0;
                            state_q <= S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    if (cfg_clr_i) begin
                        wptr_q  <= '0;
                        len_q   <= '0;
                        err_q   <= 1'b0;
                        rdy_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (start_i) begin
                        pc_q    <= '0;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
`ifdef PE_CTX_LOOP_EN
                        iter_q  <= '0;
                        loop_q  <= loop_cnt_i;
`endif
                    end
                end
                S_RUN: begin
                    if (stall_i) begin
                        // Hold pc and the issued word; downstream sees a repeat.
                    end else if (vld_q && last_q) begin
                        rf_q    <= '0;
                        rest_q  <= '0;
                        vld_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        rf_q   <= word[CTX_W-1 -: 4];
                        rest_q <= word[CTX_W-5:0];
                        vld_q  <= 1'b1;
                        last_q <= last_d;
                        pc_q   <= pc_d;
`ifdef PE_CTX_LOOP_EN
                        iter_q <= iter_d;
`endif
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_ARMED;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cfg_ready_o     = rdy_q;
    assign reg_file_inst_o = rf_q;
    assign ctx_rest_o      = rest_q;
    assign ctx_valid_o     = vld_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign cfg_err_o       = err_q;
`ifdef PE_CTX_LOOP_EN
    assign iter_o          = iter_q;
`endif

endmodule

// File: tb/tb_pe_ctx_sequencer.sv
// Directed bench for pe_ctx_sequencer: issued words are checked against a scoreboard queue.
module tb_pe_ctx_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_ready_o;
    logic [15:0] cfg_data_i = '0;
    logic        cfg_last_i = 1'b0;
    logic        cfg_clr_i = 1'b0;
    logic        start_i = 1'b0;
    logic        stall_i = 1'b0;
    logic [3:0]  reg_file_inst_o;
    logic [11:0] ctx_rest_o;
    logic        ctx_valid_o;
    logic        busy_o;
    logic        done_o;
    logic        cfg_err_o;
    logic [7:0]  obs_iter;
`ifdef PE_CTX_LOOP_EN
    logic [7:0]  loop_cnt_i = '0;
    logic [7:0]  iter_o;
    assign obs_iter = iter_o;
`else
    assign obs_iter = 8'h00;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int exp_done_cnt = 0;
    logic [23:0] exp_q [$];

    pe_ctx_sequencer #(.CTX_W(16), .DEPTH(16), .AW(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .cfg_data_i(cfg_data_i), .cfg_last_i(cfg_last_i),
        .cfg_clr_i(cfg_clr_i), .start_i(start_i), .stall_i(stall_i),
`ifdef PE_CTX_LOOP_EN
        .loop_cnt_i(loop_cnt_i), .iter_o(iter_o),
`endif
        .reg_file_inst_o(reg_file_inst_o), .ctx_rest_o(ctx_rest_o),
        .ctx_valid_o(ctx_valid_o), .busy_o(busy_o), .done_o(done_o),
        .cfg_err_o(cfg_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [15:0] w, input logic [7:0] it);
        exp_q.push_back({it, w});
    endtask

    // Scoreboard: every issuing cycle pops one expected {iter, word}.
    always @(negedge clk_i) begin
        if (done_o) done_cnt++;
        if (ctx_valid_o) begin
            chk("issue_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                chk("issue_word", {8'h0, obs_iter, reg_file_inst_o, ctx_rest_o}, {8'h0, exp_q.pop_front()});
            chk("busy_while_issuing", 32'(busy_o), 32'd1);
        end else if (!rst_i) begin
            chk("idle_outputs_zero", {16'h0, reg_file_inst_o, ctx_rest_o}, 32'h0);
        end
    end

    task automatic load(input logic [15:0] w, input logic last);
        cfg_valid_i = 1'b1;
        cfg_data_i  = w;
        cfg_last_i  = last;
        tick();
        cfg_valid_i = 1'b0;
        cfg_last_i  = 1'b0;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic clr();
        cfg_clr_i = 1'b1;
        tick();
        cfg_clr_i = 1'b0;
    endtask

    // Runs after the start edge; stall is raised after cycle st_from for st_len edges.
    task automatic run(input string tag, input int exp_done, input int st_from, input int st_len);
        int c = 0;
        int done_at = -1;
        while (done_at < 0 && c < 80) begin
            tick();
            c++;
            if (done_o) done_at = c;
            stall_i = (c >= st_from && c < st_from + st_len);
        end
        stall_i = 1'b0;
        exp_done_cnt++;
        chk({tag, "_done_cycle"}, 32'(done_at), 32'(exp_done));
        chk({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
        tick();
        chk({tag, "_done_one_cycle"}, 32'(done_o), 32'd0);
        chk({tag, "_armed_not_ready"}, {30'h0, busy_o, cfg_ready_o}, 32'd0);
    endtask

    initial begin
        logic [15:0] w;
        // Reset
        tick();
        tick();
        chk("reset_outputs", {24'h0, cfg_ready_o, ctx_valid_o, busy_o, done_o, cfg_err_o, 3'b0}, 32'h0);
        rst_i = 1'b0;
        tick();
        chk("ready_after_reset", 32'(cfg_ready_o), 32'd1);

        // Three-word program
        load(16'hA001, 1'b0);
        load(16'h5002, 1'b0);
        load(16'hF003, 1'b1);
        chk("armed_ready_low", 32'(cfg_ready_o), 32'd0);
        chk("armed_no_err", 32'(cfg_err_o), 32'd0);
        push(16'hA001, 8'd0); push(16'h5002, 8'd0); push(16'hF003, 8'd0);
        do_start();
        run("three", 4, 0, 0);

        // Re-run retained program, stalling while word 1 is issued
        push(16'hA001, 8'd0);
        push(16'h5002, 8'd0); push(16'h5002, 8'd0); push(16'h5002, 8'd0);
        push(16'hF003, 8'd0);
        do_start();
        run("stall", 6, 2, 2);

        // cfg_clr beats simultaneous start; start in IDLE ignored
        cfg_clr_i = 1'b1;
        start_i   = 1'b1;
        tick();
        cfg_clr_i = 1'b0;
        start_i   = 1'b0;
        chk("clr_to_idle_ready", 32'(cfg_ready_o), 32'd1);
        chk("clr_busy_low", 32'(busy_o), 32'd0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        chk("idle_start_ignored", {30'h0, busy_o, ctx_valid_o}, 32'd0);
        chk("idle_still_ready", 32'(cfg_ready_o), 32'd1);

        // Sixteen words, no cfg_last: truncated program
        for (int i = 0; i < 16; i++) begin
            w = {4'(i), 12'(i * 291 + 5)};
            push(w, 8'd0);
            load(w, 1'b0);
        end
        chk("trunc_err", 32'(cfg_err_o), 32'd1);
        chk("trunc_ready_low", 32'(cfg_ready_o), 32'd0);
        do_start();
        run("sixteen", 17, 0, 0);
        chk("err_sticky", 32'(cfg_err_o), 32'd1);

        // Reset during issue of word 2 of 4
        clr();
        chk("clr_err", 32'(cfg_err_o), 32'd0);
        load(16'h1111, 1'b0);
        load(16'h2222, 1'b0);
        load(16'h3333, 1'b0);
        load(16'h4444, 1'b1);
        push(16'h1111, 8'd0); push(16'h2222, 8'd0); push(16'h3333, 8'd0);
        do_start();
        tick();
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        chk("abort_outputs", {27'h0, ctx_valid_o, busy_o, done_o, 1'b0, cfg_ready_o}, 32'h0);
        chk("abort_zero_word", {16'h0, reg_file_inst_o, ctx_rest_o}, 32'h0);
        rst_i = 1'b0;
        tick();
        chk("abort_ready", 32'(cfg_ready_o), 32'd1);
        tick();
        tick();
        chk("abort_no_done", 32'(done_cnt), 32'(exp_done_cnt));
        chk("abort_queue_drained", 32'(exp_q.size()), 32'd0);

`ifdef PE_CTX_LOOP_EN
        load(16'hC0DE, 1'b0);
        load(16'h7BAD, 1'b1);
        for (int p = 0; p < 3; p++) begin
            push(16'hC0DE, 8'(p));
            push(16'h7BAD, 8'(p));
        end
        loop_cnt_i = 8'd2;
        do_start();
        loop_cnt_i = 8'd0;
        run("loop", 7, 0, 0);
`endif

        tick();
        chk("done_pulse_count", 32'(done_cnt), 32'(exp_done_cnt));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
